// File: rtl/deserializer_fsm.sv
// deserializer_fsm: LSB-first serial-to-parallel word assembler with valid/ready output and gap watchdog.
// Build option: define DESER_PARITY_EN to append an even-parity bit per word and expose o_parity_err.
module deserializer_fsm #(
    parameter int LENGTH  = 24,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_ready,
`ifdef DESER_PARITY_EN
    output logic              o_parity_err,
`endif
    output logic              o_frame_err
);

    localparam int CNT_W = $clog2(LENGTH + 1);
    localparam int GAP_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2,
        S_PARITY  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;
`endif

    state_t              r_state;
    logic [LENGTH-1:0]   r_shift;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [GAP_W-1:0]    r_gap;

    logic                w_accept;
    logic [LENGTH-1:0]   w_word;
    logic                w_last;
    logic                w_held;
    logic                w_timeout;
    logic [GAP_W-1:0]    w_gap_next;

    // Accept/shift/watchdog decode shared by every state
    always_comb begin
        w_accept = i_en & i_din_valid & o_ready;
        w_word   = {i_din, r_shift[LENGTH-1:1]};
        w_last   = (r_bit_cnt == CNT_W'(LENGTH - 1));
        case (r_state)
            S_COLLECT: w_held = (r_bit_cnt != CNT_W'(0));
`ifdef DESER_PARITY_EN
            S_PARITY:  w_held = 1'b1;
`endif
            default:   w_held = 1'b0;
        endcase
        // Gap only counts while a partial word is at risk; it is cleared on timeout so it never wraps
        if ((TIMEOUT > 0) && w_held && !w_accept) begin
            w_gap_next = r_gap + GAP_W'(1);
            w_timeout  = (r_gap == GAP_W'(TIMEOUT - 1));
        end else begin
            w_gap_next = GAP_W'(0);
            w_timeout  = 1'b0;
        end
    end

    // Main FSM with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= CNT_W'(0);
            r_gap        <= GAP_W'(0);
            o_ready      <= 1'b0;
            ov_dout      <= '0;
            o_dout_valid <= 1'b0;
            o_frame_err  <= 1'b0;
`ifdef DESER_PARITY_EN
            o_parity_err <= 1'b0;
`endif
        end else if (i_en) begin
            o_frame_err <= 1'b0;
            r_gap       <= w_gap_next;
            case (r_state)
                S_IDLE: begin
                    o_ready <= 1'b1;
                    r_state <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_shift <= w_word;
                        if (w_last) begin
                            ov_dout   <= w_word;
                            r_bit_cnt <= CNT_W'(0);
`ifdef DESER_PARITY_EN
                            r_state   <= S_PARITY;
`else
                            o_dout_valid <= 1'b1;
                            o_ready      <= 1'b0;
                            r_state      <= S_HOLD;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_shift     <= '0;
                        r_bit_cnt   <= CNT_W'(0);
                        r_gap       <= GAP_W'(0);
                        o_frame_err <= 1'b1;
                    end
                end
`ifdef DESER_PARITY_EN
                S_PARITY: begin
                    // ov_dout already carries the data bits loaded on entry
                    if (w_accept) begin
                        o_parity_err <= (^ov_dout) ^ i_din;
                        o_dout_valid <= 1'b1;
                        o_ready      <= 1'b0;
                        r_state      <= S_HOLD;
                    end else if (w_timeout) begin
                        r_shift     <= '0;
                        r_bit_cnt   <= CNT_W'(0);
                        r_gap       <= GAP_W'(0);
                        o_frame_err <= 1'b1;
                        r_state     <= S_COLLECT;
                    end
                end
`endif
                S_HOLD: begin
                    if (i_ready) begin
                        o_dout_valid <= 1'b0;
                        o_ready      <= 1'b1;
                        r_state      <= S_COLLECT;
`ifdef DESER_PARITY_EN
                        o_parity_err <= 1'b0;
`endif
                    end
                end
                default: begin
                    o_ready      <= 1'b0;
                    o_dout_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
